// File: rtl/mulmod128_reduce_pipe_pkg.sv
// mulmod128_reduce_pipe_pkg: widths and constants for reduction modulo P = 2^64 - 2^32 + 1
package mulmod128_reduce_pipe_pkg;
    localparam int P_WIDTH = 64;
    localparam int W_WIDTH = 32;
    localparam int PD_WIDTH = 128;
    localparam int TAG_WIDTH = 8;
    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] EPS = 64'h0000_0000_FFFF_FFFF;
endpackage

// File: rtl/mulmod128_reduce_pipe_stage.sv
// mulmod_pipe_stage: valid/tag/data pipeline register, holds on stall, captures payload only when valid
module mulmod_pipe_stage #(
    parameter int D_WIDTH = 64,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 valid_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic [D_WIDTH-1:0]   data_in,
    output logic                 valid,
    output logic [TAG_WIDTH-1:0] tag,
    output logic [D_WIDTH-1:0]   data
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            tag <= '0;
            data <= '0;
        end else if (en) begin
            valid <= valid_in;
            if (valid_in) begin
                tag <= tag_in;
                data <= data_in;
            end
        end
endmodule

// File: rtl/mulmod128_reduce_pipe.sv
// mulmod128_reduce_pipe: 3-stage valid/ready pipeline reducing a 128-bit product x (Mul_in, tag_in) to x mod P (res_out, tag_out)
module mulmod128_reduce_pipe #(
    parameter int P_WIDTH = mulmod128_reduce_pipe_pkg::P_WIDTH,
    parameter int PD_WIDTH = mulmod128_reduce_pipe_pkg::PD_WIDTH,
    parameter int W_WIDTH = mulmod128_reduce_pipe_pkg::W_WIDTH,
    parameter int TAG_WIDTH = mulmod128_reduce_pipe_pkg::TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PD_WIDTH-1:0]  Mul_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P_WIDTH-1:0]   res_out,
    output logic [TAG_WIDTH-1:0] tag_out
);
    import mulmod128_reduce_pipe_pkg::P;
    import mulmod128_reduce_pipe_pkg::EPS;
    logic                   stall;
    logic                   v1, v2;
    logic [TAG_WIDTH-1:0]   t1, t2;
    logic [2*P_WIDTH-1:0]   s1_q;
    logic [P_WIDTH-1:0]     s2_q;
    logic [W_WIDTH-1:0]     a, b;
    logic [P_WIDTH:0]       d_full, s_full;
    logic [P_WIDTH-1:0]     d_n, m_n, s_n, r_n;
    assign stall = out_valid & ~out_ready;
    assign in_ready = ~stall;
    always_comb begin
        a = Mul_in[PD_WIDTH-1 -: W_WIDTH];
        b = Mul_in[P_WIDTH +: W_WIDTH];
        d_full = {1'b0, Mul_in[P_WIDTH-1:0]} - {{(P_WIDTH-W_WIDTH+1){1'b0}}, a};
        d_n = d_full[P_WIDTH] ? d_full[P_WIDTH-1:0] - EPS : d_full[P_WIDTH-1:0];
        m_n = {b, {W_WIDTH{1'b0}}} - {{W_WIDTH{1'b0}}, b};
        s_full = {1'b0, s1_q[2*P_WIDTH-1:P_WIDTH]} + {1'b0, s1_q[P_WIDTH-1:0]};
        s_n = s_full[P_WIDTH] ? s_full[P_WIDTH-1:0] + EPS : s_full[P_WIDTH-1:0];
        r_n = (s2_q >= P) ? s2_q - P : s2_q;
    end
    mulmod_pipe_stage #(.D_WIDTH(2*P_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_s1 (
        .clk(clk), .rst_n(rst_n), .en(~stall), .valid_in(in_valid & in_ready),
        .tag_in(tag_in), .data_in({d_n, m_n}), .valid(v1), .tag(t1), .data(s1_q)
    );
    mulmod_pipe_stage #(.D_WIDTH(P_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_s2 (
        .clk(clk), .rst_n(rst_n), .en(~stall), .valid_in(v1),
        .tag_in(t1), .data_in(s_n), .valid(v2), .tag(t2), .data(s2_q)
    );
    mulmod_pipe_stage #(.D_WIDTH(P_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_s3 (
        .clk(clk), .rst_n(rst_n), .en(~stall), .valid_in(v2),
        .tag_in(t2), .data_in(r_n), .valid(out_valid), .tag(tag_out), .data(res_out)
    );
endmodule

// File: tb/tb_mulmod128_reduce_pipe.sv
// tb_mulmod128_reduce_pipe: directed and random checks of mulmod128_reduce_pipe against a modulo reference model
module tb_mulmod128_reduce_pipe;
    localparam logic [127:0] PM = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0001;
    typedef struct packed {
        logic [7:0]  tag;
        logic [63:0] res;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] mul_in = '0;
    logic [7:0]   tag_in = '0;
    logic         in_ready, out_valid;
    logic [63:0]  res_out;
    logic [7:0]   tag_out;
    int           checks = 0;
    int           failures = 0;
    int           acc_count = 0;
    exp_t         q[$];
    logic         prev_stall = 1'b0;
    logic [63:0]  prev_res;
    logic [7:0]   prev_tag;

    mulmod128_reduce_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Mul_in(mul_in), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .res_out(res_out), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [127:0] x);
        logic [127:0] r;
        r = x % PM;
        return r[63:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_res", res_out, prev_res);
                chk("hold_tag", 64'(tag_out), 64'(prev_tag));
            end
            if (in_valid && in_ready) begin
                q.push_back({tag_in, model(mul_in)});
                acc_count++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_res", res_out, e.res);
                    chk("sb_tag", 64'(tag_out), 64'(e.tag));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res = res_out;
            prev_tag = tag_out;
        end else prev_stall = 1'b0;
    end

    task automatic directed(input string name, input logic [127:0] x, input logic [7:0] t, input logic [63:0] req);
        @(posedge clk); #1;
        in_valid = 1'b1; mul_in = x; tag_in = t; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({name, "_lat2"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({name, "_lat3"}, 64'(out_valid), 64'd1);
        chk({name, "_res"}, res_out, req);
        chk({name, "_tag"}, 64'(tag_out), 64'(t));
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res", res_out, 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        @(posedge clk); #3; rst_n = 1'b1;

        chk("model_pm1sq", model(128'hFFFF_FFFE_0000_0001_0000_0000_0000_0000), 64'd1);
        chk("model_all1", model({128{1'b1}}), 64'hFFFF_FFFE_0000_0000);
        chk("model_2p96", model(128'h1 << 96), 64'hFFFF_FFFF_0000_0000);

        directed("zero", 128'd0, 8'h11, 64'd0);
        directed("eq_p", PM, 8'h22, 64'd0);
        directed("p2_64", 128'h1 << 64, 8'h33, 64'h0000_0000_FFFF_FFFF);
        directed("p2_96", 128'h1 << 96, 8'h44, 64'hFFFF_FFFF_0000_0000);
        directed("pm1sq", 128'hFFFF_FFFE_0000_0001_0000_0000_0000_0000, 8'h55, 64'd1);
        directed("all1", {128{1'b1}}, 8'h66, 64'hFFFF_FFFE_0000_0000);
        directed("c_eq_p", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 8'h77, 64'h0000_0000_FFFF_FFFE);
        drain("drain_directed");

        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; mul_in = rnd128(); tag_in = 8'(i); out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stream_throughput", 64'(q.size()), 64'd0);

        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; mul_in = rnd128(); tag_in = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        mul_in = rnd128(); tag_in = 8'hA3;
        repeat (5) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("drain_backpressure");

        for (int i = 0; i < 60000 && acc_count < 12000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            mul_in = rnd128();
            tag_in = 8'($urandom);
        end
        chk("random_accepts", 64'(acc_count >= 12000), 64'd1);
        drain("drain_random");

        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; mul_in = rnd128(); tag_in = 8'hC0;
        @(posedge clk); #1;
        mul_in = rnd128(); tag_in = 8'hC1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_rst_no_out", 64'(out_valid), 64'd0);
        end
        directed("post_rst_a", 128'h1 << 64, 8'hD0, 64'h0000_0000_FFFF_FFFF);
        directed("post_rst_b", 128'hFFFF_FFFE_0000_0001_0000_0000_0000_0000, 8'hD1, 64'd1);
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
